// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word read at a time, decodes
// the register fields, builds a short or extended immediate and hands it downstream.
module fetch_unit #(
   parameter int unsigned     PC_W     = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic [PC_W-1:0] imem_addr,
   output logic            imem_req,
   input  logic [31:0]     imem_rdata,
   input  logic            imem_valid,
   input  logic            redirect_valid,
   input  logic [PC_W-1:0] redirect_pc,
   input  logic            out_ready_f,
   output logic            out_valid_f,
   output logic [4:0]      opcode_out_f,
   output logic [3:0]      dest_out_f,
   output logic [3:0]      s1_out_f,
   output logic [3:0]      s2_out_f,
   output logic [31:0]     ime_data_out_f,
   output logic [PC_W-1:0] pc_out_f
);

   localparam int unsigned WORD_W      = 32;
   localparam int unsigned IMM_SHORT_W = 14;
   localparam int unsigned EXT_BIT     = 14;

   typedef enum logic [2:0] {REQ0, WAIT0, REQ1, WAIT1, OUT} state_e;

   state_e            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [PC_W-1:0]   addr_q, addr_d;
   logic [PC_W-1:0]   pc_out_q, pc_out_d;
   logic              drop_q, drop_d;
   logic              req_q, req_d;
   logic              valid_q, valid_d;
   logic [4:0]        opcode_q, opcode_d;
   logic [3:0]        dest_q, dest_d;
   logic [3:0]        s1_q, s1_d;
   logic [3:0]        s2_q, s2_d;
   logic [WORD_W-1:0] imm_q, imm_d;

   logic              take_c;
   logic              in_wait_c;
   logic [WORD_W-1:0] short_imm_c;

   // Read data arriving together with a redirect belongs to the old path.
   assign take_c      = imem_valid & ~redirect_valid;
   assign in_wait_c   = (state_q == WAIT0) || (state_q == WAIT1);
   assign short_imm_c = {{(WORD_W - IMM_SHORT_W){imem_rdata[IMM_SHORT_W-1]}},
                         imem_rdata[IMM_SHORT_W-1:0]};

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      drop_d   = drop_q;
      opcode_d = opcode_q;
      dest_d   = dest_q;
      s1_d     = s1_q;
      s2_d     = s2_q;
      imm_d    = imm_q;
      pc_out_d = pc_out_q;
      req_d    = 1'b0;
      addr_d   = addr_q;
      valid_d  = 1'b0;

      case (state_q)
         // req_q marks the cycle the request is actually on the bus.
         REQ0: begin
            if (drop_q && imem_valid) begin
               drop_d = 1'b0;
            end else if (req_q) begin
               state_d = WAIT0;
            end
         end
         WAIT0: begin
            if (take_c) begin
               opcode_d = imem_rdata[31:27];
               dest_d   = imem_rdata[26:23];
               s1_d     = imem_rdata[22:19];
               s2_d     = imem_rdata[18:15];
               pc_out_d = pc_q;
               if (imem_rdata[EXT_BIT]) begin
                  state_d = REQ1;
               end else begin
                  imm_d   = short_imm_c;
                  pc_d    = pc_q + PC_W'(1);
                  state_d = OUT;
               end
            end
         end
         REQ1: state_d = WAIT1;
         WAIT1: begin
            if (take_c) begin
               imm_d   = imem_rdata;
               pc_d    = pc_q + PC_W'(2);
               state_d = OUT;
            end
         end
         OUT: begin
            if (out_ready_f) state_d = REQ0;
         end
         default: state_d = REQ0;
      endcase

      // Redirect wins; any read still in flight must be swallowed on return.
      if (redirect_valid) begin
         state_d = REQ0;
         pc_d    = redirect_pc;
         drop_d  = req_q || ((in_wait_c || drop_q) && !imem_valid);
      end

      req_d = ((state_d == REQ0) && !drop_d) || (state_d == REQ1);
      if (req_d) addr_d = (state_d == REQ1) ? pc_d + PC_W'(1) : pc_d;
      valid_d = (state_d == OUT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= REQ0;
         pc_q     <= RESET_PC;
         addr_q   <= '0;
         pc_out_q <= '0;
         drop_q   <= 1'b0;
         req_q    <= 1'b0;
         valid_q  <= 1'b0;
         opcode_q <= '0;
         dest_q   <= '0;
         s1_q     <= '0;
         s2_q     <= '0;
         imm_q    <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         addr_q   <= addr_d;
         pc_out_q <= pc_out_d;
         drop_q   <= drop_d;
         req_q    <= req_d;
         valid_q  <= valid_d;
         opcode_q <= opcode_d;
         dest_q   <= dest_d;
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         imm_q    <= imm_d;
      end
   end

   assign imem_addr      = addr_q;
   assign imem_req       = req_q;
   assign out_valid_f    = valid_q;
   assign opcode_out_f   = opcode_q;
   assign dest_out_f     = dest_q;
   assign s1_out_f       = s1_q;
   assign s2_out_f       = s2_q;
   assign ime_data_out_f = imm_q;
   assign pc_out_f       = pc_out_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, multi-cycle corner sequences and
// a randomized run scored against a program-walk reference model.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] imem_addr;
   logic        imem_req;
   logic [31:0] imem_rdata;
   logic        imem_valid;
   logic        redirect_valid = 1'b0;
   logic [15:0] redirect_pc = '0;
   logic        out_ready_f = 1'b0;
   logic        out_valid_f;
   logic [4:0]  opcode_out_f;
   logic [3:0]  dest_out_f, s1_out_f, s2_out_f;
   logic [31:0] ime_data_out_f;
   logic [15:0] pc_out_f;

   fetch_unit #(.PC_W(16), .RESET_PC(16'h0000)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_addr(imem_addr), .imem_req(imem_req),
      .imem_rdata(imem_rdata), .imem_valid(imem_valid),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_ready_f(out_ready_f), .out_valid_f(out_valid_f),
      .opcode_out_f(opcode_out_f), .dest_out_f(dest_out_f),
      .s1_out_f(s1_out_f), .s2_out_f(s2_out_f),
      .ime_data_out_f(ime_data_out_f), .pc_out_f(pc_out_f)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- memory model ----------------
   logic [31:0] mem [0:65535];
   int unsigned lat_min = 1, lat_max = 1;
   int unsigned cnt = 0;
   logic        busy = 1'b0, prev_req = 1'b0;
   logic [15:0] paddr = '0;
   logic        mem_valid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        inj_valid = 1'b0;
   logic [31:0] inj_data = '0;
   logic [15:0] req_log[$];

   assign imem_valid = mem_valid | inj_valid;
   assign imem_rdata = inj_valid ? inj_data : mem_rdata;

   always @(negedge clk) begin
      mem_valid = 1'b0;
      if (!rst_n) begin
         busy = 1'b0;
         prev_req = 1'b0;
         req_log.delete();
      end else begin
         if (busy) begin
            cnt--;
            if (cnt == 0) begin
               mem_valid = 1'b1;
               mem_rdata = mem[paddr];
               busy = 1'b0;
            end
         end
         if (imem_req) begin
            check("req_back_to_back", prev_req, 1'b0);
            check("one_outstanding", busy, 1'b0);
            busy = 1'b1;
            cnt = $urandom_range(lat_max, lat_min);
            paddr = imem_addr;
            req_log.push_back(imem_addr);
         end
         prev_req = imem_req;
      end
   end

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [4:0]  op;
      logic [3:0]  d;
      logic [3:0]  s1;
      logic [3:0]  s2;
      logic [31:0] imm;
      logic [15:0] pc;
   } instr_t;

   instr_t dut_instr;
   assign dut_instr = {opcode_out_f, dest_out_f, s1_out_f, s2_out_f, ime_data_out_f, pc_out_f};

   function automatic instr_t ref_instr(input logic [15:0] pc);
      instr_t      r;
      logic [31:0] w0;
      w0 = mem[pc];
      r.op = w0[31:27];
      r.d  = w0[26:23];
      r.s1 = w0[22:19];
      r.s2 = w0[18:15];
      r.pc = pc;
      if (w0[14]) r.imm = mem[16'(pc + 16'd1)];
      else        r.imm = 32'(w0[13:0]) - (w0[13] ? 32'h0000_4000 : 32'h0);
      return r;
   endfunction

   function automatic logic [15:0] ref_len(input logic [15:0] pc);
      logic [31:0] w0;
      w0 = mem[pc];
      return w0[14] ? 16'd2 : 16'd1;
   endfunction

   // ---------------- helpers ----------------
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      redirect_valid = 1'b0;
      out_ready_f = 1'b0;
      inj_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_req(output logic [15:0] addr, output int n);
      n = 0;
      while (!imem_req && n < 50) begin
         @(negedge clk);
         n++;
      end
      addr = imem_addr;
      if (!imem_req) check("req_timeout", 1'b0, 1'b1);
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!out_valid_f && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid_f) check("valid_timeout", 1'b0, 1'b1);
   endtask

   typedef struct {
      logic        redir;
      logic [15:0] start;
      logic [31:0] w0, w1;
      logic [4:0]  op;
      logic [3:0]  d, s1, s2;
      logic [31:0] imm;
      logic [15:0] next, last_req;
      int          lat;
   } vec_t;

   task automatic run_vec(input vec_t v);
      logic [15:0] a;
      int          n;
      lat_min = 1; lat_max = 1;
      mem[v.start] = v.w0;
      mem[16'(v.start + 16'd1)] = v.w1;
      do_reset();
      if (v.redir) begin
         redirect_valid = 1'b1;
         redirect_pc = v.start;
      end
      @(negedge clk);
      redirect_valid = 1'b0;
      wait_req(a, n);
      check("vec_first_addr", a, v.start);
      wait_valid(n);
      check("vec_latency", n, v.lat);
      check("vec_opcode", opcode_out_f, v.op);
      check("vec_dest", dest_out_f, v.d);
      check("vec_s1", s1_out_f, v.s1);
      check("vec_s2", s2_out_f, v.s2);
      check("vec_imm", ime_data_out_f, v.imm);
      check("vec_pc_out", pc_out_f, v.start);
      check("vec_last_req", req_log[req_log.size() - 1], v.last_req);
      out_ready_f = 1'b1;
      @(negedge clk);
      out_ready_f = 1'b0;
      check("vec_valid_drop", out_valid_f, 1'b0);
      check("vec_next_req", {imem_req, imem_addr}, {1'b1, v.next});
   endtask

   vec_t        vecs[6];
   logic [15:0] a, model_pc, tgt;
   int          n, nhs;
   logic [79:0] snap;
   logic        saw_valid, rdy, rd;

   initial begin
      vecs[0] = '{1'b0, 16'h0000, 32'h0890_1FFF, 32'h0, 5'd1, 4'd1, 4'd2, 4'd0, 32'h0000_1FFF, 16'h0001, 16'h0000, 2};
      vecs[1] = '{1'b1, 16'h0004, 32'h1000_4000, 32'hDEAD_BEEF, 5'd2, 4'd0, 4'd0, 4'd0, 32'hDEAD_BEEF, 16'h0006, 16'h0005, 4};
      vecs[2] = '{1'b1, 16'hFFFF, 32'h1000_4000, 32'h1234_5678, 5'd2, 4'd0, 4'd0, 4'd0, 32'h1234_5678, 16'h0001, 16'h0000, 4};
      vecs[3] = '{1'b1, 16'h0100, 32'hFFFF_A001, 32'h0, 5'd31, 4'd15, 4'd15, 4'd15, 32'hFFFF_E001, 16'h0101, 16'h0100, 2};
      vecs[4] = '{1'b1, 16'hFFFF, 32'h0000_0000, 32'h0, 5'd0, 4'd0, 4'd0, 4'd0, 32'h0, 16'h0000, 16'hFFFF, 2};
      vecs[5] = '{1'b1, 16'h0200, 32'h0000_7FFF, 32'h8000_0001, 5'd0, 4'd0, 4'd0, 4'd0, 32'h8000_0001, 16'h0202, 16'h0201, 4};

      #12;
      check("reset_outputs", {imem_req, imem_addr, out_valid_f, dut_instr}, '0);

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Back-pressure: fields frozen, no fetch while out_ready_f is low.
      mem[0] = 32'h0890_1FFF;
      lat_min = 1; lat_max = 1;
      do_reset();
      @(negedge clk);
      wait_req(a, n);
      wait_valid(n);
      snap = {out_valid_f, dut_instr};
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("hold_fields", {out_valid_f, dut_instr}, snap);
         check("hold_no_req", imem_req, 1'b0);
      end
      out_ready_f = 1'b1;
      @(negedge clk);
      out_ready_f = 1'b0;
      check("hold_release", {out_valid_f, imem_req, imem_addr}, {1'b0, 1'b1, 16'h0001});

      // Redirect in WAIT0 with slow memory: stale word must be swallowed.
      mem[16'h0040] = 32'h2800_0005;
      lat_min = 3; lat_max = 3;
      do_reset();
      @(negedge clk);
      wait_req(a, n);
      check("drop_first_addr", a, 16'h0000);
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc = 16'h0040;
      @(negedge clk);
      redirect_valid = 1'b0;
      n = 2;
      saw_valid = 1'b0;
      while (!imem_req && n < 30) begin
         saw_valid |= out_valid_f;
         @(negedge clk);
         n++;
      end
      check("drop_req_gap", n, 4);
      check("drop_new_addr", imem_addr, 16'h0040);
      check("drop_no_stale_valid", saw_valid, 1'b0);
      wait_valid(n);
      check("drop_result", {pc_out_f, opcode_out_f, ime_data_out_f}, {16'h0040, 5'd5, 32'h5});

      // Reset during WAIT1, then a late stray valid in REQ0.
      mem[4] = 32'h1000_4000;
      mem[5] = 32'hDEAD_BEEF;
      lat_min = 2; lat_max = 2;
      do_reset();
      redirect_valid = 1'b1;
      redirect_pc = 16'h0004;
      @(negedge clk);
      redirect_valid = 1'b0;
      wait_req(a, n);
      @(negedge clk);
      wait_req(a, n);
      check("rst_second_addr", a, 16'h0005);
      @(negedge clk);
      check("rst_wait1_latched", {opcode_out_f, pc_out_f}, {5'd2, 16'h0004});
      rst_n = 1'b0;
      #1;
      check("rst_async_clear", {imem_req, imem_addr, out_valid_f, dut_instr}, '0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      inj_valid = 1'b1;
      inj_data = 32'hFFFF_FFFF;
      @(negedge clk);
      inj_valid = 1'b0;
      check("rst_first_req", {imem_req, imem_addr}, {1'b1, 16'h0000});
      wait_valid(n);
      check("rst_first_instr", dut_instr, ref_instr(16'h0000));

      // Randomized run against the program-walk model.
      for (int i = 0; i < 65536; i++) mem[i] = $urandom;
      lat_min = 1; lat_max = 3;
      do_reset();
      model_pc = 16'h0000;
      nhs = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         rdy = ($urandom_range(0, 3) != 0);
         rd  = ($urandom_range(0, 24) == 0);
         tgt = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
         if (out_valid_f && rdy) begin
            check("rand_instr", dut_instr, ref_instr(model_pc));
            model_pc = model_pc + ref_len(model_pc);
            nhs++;
         end
         if (rd) model_pc = tgt;
         out_ready_f = rdy;
         redirect_valid = rd;
         redirect_pc = tgt;
         @(negedge clk);
      end
      out_ready_f = 1'b0;
      redirect_valid = 1'b0;
      check("rand_progress", nhs >= 100, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
